// File: rtl/bn_param_calc.sv
// rtl/bn_param_calc.sv - folds std/mean/gamma/beta into per-channel scale a and shift b
module bn_param_calc #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int CHANNELS   = 64,
   parameter int CH_WIDTH   = $clog2(CHANNELS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CH_WIDTH-1:0]   ch_in,
   input  logic [DATA_WIDTH-1:0] g_stan_dev_in,
   input  logic [DATA_WIDTH-1:0] g_avg_in,
   input  logic [DATA_WIDTH-1:0] gamma_in,
   input  logic [DATA_WIDTH-1:0] beta_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CH_WIDTH-1:0]   ch_out,
   output logic [DATA_WIDTH-1:0] a_out,
   output logic [DATA_WIDTH-1:0] b_out,
   output logic                  sat_out,
   output logic                  err_out
);

   localparam int N     = DATA_WIDTH + FRAC_BITS;
   localparam int CNT_W = $clog2(N + 1);
   localparam int PW    = 2 * DATA_WIDTH;
   localparam logic [N-1:0] POS_LIM = N'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
   localparam logic [N-1:0] NEG_LIM = N'(64'd1 << (DATA_WIDTH - 1));
   localparam logic [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, DIV, MUL, OUT} state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt;
   logic [N-1:0]          dq;        // dividend bits shift out the top, quotient bits shift in the bottom
   logic [DATA_WIDTH-1:0] rem;
   logic [DATA_WIDTH-1:0] divisor;
   logic [DATA_WIDTH-1:0] mean_r;
   logic [DATA_WIDTH-1:0] beta_r;
   logic [CH_WIDTH-1:0]   ch_r;
   logic                  q_neg;

   logic                  accept;
   logic                  bypass;
   logic [DATA_WIDTH-1:0] g_mag;
   logic [DATA_WIDTH:0]   trial;
   logic                  trial_ge;
   logic [DATA_WIDTH-1:0] a_sat;
   logic                  a_ovf;
   logic signed [PW-1:0]  a_ext;
   logic signed [PW-1:0]  m_ext;
   logic signed [PW-1:0]  prod;
   logic signed [PW-1:0]  p_shift;
   logic [PW:0]           b_wide;
   logic                  b_fits;
   logic [DATA_WIDTH-1:0] b_sat;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == OUT);
   assign accept    = in_valid & in_ready;
   assign bypass    = g_stan_dev_in[DATA_WIDTH-1] | (g_stan_dev_in == '0);
   assign g_mag     = gamma_in[DATA_WIDTH-1] ? -gamma_in : gamma_in;

   assign trial     = {rem, dq[N-1]};
   assign trial_ge  = (trial >= {1'b0, divisor});

   // Signed, saturated scale from the unsigned quotient magnitude
   always_comb begin
      a_sat = dq[DATA_WIDTH-1:0];
      a_ovf = 1'b0;
      if (q_neg) begin
         if (dq > NEG_LIM) begin
            a_sat = D_MIN;
            a_ovf = 1'b1;
         end else begin
            a_sat = -dq[DATA_WIDTH-1:0];
         end
      end else if (dq > POS_LIM) begin
         a_sat = D_MAX;
         a_ovf = 1'b1;
      end
   end

   assign a_ext   = {{DATA_WIDTH{a_sat[DATA_WIDTH-1]}}, a_sat};
   assign m_ext   = {{DATA_WIDTH{mean_r[DATA_WIDTH-1]}}, mean_r};
   assign prod    = a_ext * m_ext;
   assign p_shift = prod >>> FRAC_BITS;
   assign b_wide  = {{(PW+1-DATA_WIDTH){beta_r[DATA_WIDTH-1]}}, beta_r} - {p_shift[PW-1], p_shift};
   // b fits when every bit above the target sign bit matches it
   assign b_fits  = (b_wide[PW:DATA_WIDTH-1] == '0) | (b_wide[PW:DATA_WIDTH-1] == '1);
   assign b_sat   = b_fits ? b_wide[DATA_WIDTH-1:0] : (b_wide[PW] ? D_MIN : D_MAX);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: bypass skips straight to OUT, division runs N cycles
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = bypass ? OUT : DIV;
         DIV:  if (cnt == CNT_W'(N - 1)) state_nxt = MUL;
         MUL:  state_nxt = OUT;
         OUT:  if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, restoring division step, and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         dq      <= '0;
         rem     <= '0;
         divisor <= '0;
         mean_r  <= '0;
         beta_r  <= '0;
         ch_r    <= '0;
         q_neg   <= 1'b0;
         ch_out  <= '0;
         a_out   <= '0;
         b_out   <= '0;
         sat_out <= 1'b0;
         err_out <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               ch_r    <= ch_in;
               mean_r  <= g_avg_in;
               beta_r  <= beta_in;
               divisor <= g_stan_dev_in;
               q_neg   <= gamma_in[DATA_WIDTH-1] ^ g_stan_dev_in[DATA_WIDTH-1];
               dq      <= N'(g_mag) << FRAC_BITS;
               rem     <= '0;
               cnt     <= '0;
               if (bypass) begin
                  ch_out  <= ch_in;
                  a_out   <= '0;
                  b_out   <= beta_in;
                  sat_out <= 1'b0;
                  err_out <= 1'b1;
               end
            end
            DIV: begin
               rem <= trial_ge ? (trial[DATA_WIDTH-1:0] - divisor) : trial[DATA_WIDTH-1:0];
               dq  <= {dq[N-2:0], trial_ge};
               cnt <= cnt + CNT_W'(1);
            end
            MUL: begin
               ch_out  <= ch_r;
               a_out   <= a_sat;
               b_out   <= b_sat;
               sat_out <= a_ovf | ~b_fits;
               err_out <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bn_param_calc.sv
// tb/tb_bn_param_calc.sv - randomized and directed checks of bn_param_calc against a behavioural model
module tb_bn_param_calc;
   localparam int DW = 16;
   localparam int FB = 8;
   localparam int CW = 6;
   localparam int N  = DW + FB;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] ch_in;
   logic [DW-1:0] g_stan_dev_in, g_avg_in, gamma_in, beta_in;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] ch_out;
   logic [DW-1:0] a_out, b_out;
   logic          sat_out, err_out;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit rand_ready = 1'b0;

   typedef struct {
      logic [CW-1:0] ch;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          sat;
      logic          err;
      int            rdy;
   } exp_t;
   exp_t exp_q[$];

   bn_param_calc #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .CHANNELS(64), .CH_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ch_in(ch_in),
      .g_stan_dev_in(g_stan_dev_in), .g_avg_in(g_avg_in), .gamma_in(gamma_in), .beta_in(beta_in),
      .out_valid(out_valid), .out_ready(out_ready), .ch_out(ch_out), .a_out(a_out), .b_out(b_out),
      .sat_out(sat_out), .err_out(err_out)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endfunction

   // Reference: a = trunc(gamma*2^F/std), b = beta - floor(a*mean/2^F), both saturated
   function automatic void model(input logic [DW-1:0] s_in, m_in, g_in, b_in,
                                 output logic [DW-1:0] a, b, output logic sat, err);
      longint s, m, g, bb, q, p, r, hi, lo;
      hi  = (longint'(1) <<< (DW - 1)) - 1;
      lo  = -(longint'(1) <<< (DW - 1));
      s   = longint'($signed(s_in));
      m   = longint'($signed(m_in));
      g   = longint'($signed(g_in));
      bb  = longint'($signed(b_in));
      sat = 1'b0;
      err = 1'b0;
      if (s <= 0) begin
         a   = '0;
         b   = b_in;
         err = 1'b1;
         return;
      end
      q = (g * (longint'(1) <<< FB)) / s;
      if (q > hi) begin q = hi; sat = 1'b1; end
      else if (q < lo) begin q = lo; sat = 1'b1; end
      p = (q * m) >>> FB;
      r = bb - p;
      if (r > hi) begin r = hi; sat = 1'b1; end
      else if (r < lo) begin r = lo; sat = 1'b1; end
      a = q[DW-1:0];
      b = r[DW-1:0];
   endfunction

   // Cycle-level compare against the model queue; predicts accept/consume at the coming edge
   always @(negedge clk) begin
      exp_t e;
      bit ev;
      if (!rst_n) begin
         exp_q.delete();
         chk("rst in_ready", in_ready, 1);
         chk("rst out_valid", out_valid, 0);
      end else begin
         ev = (exp_q.size() != 0) && (cyc >= exp_q[0].rdy);
         chk("in_ready", in_ready, exp_q.size() == 0);
         chk("out_valid", out_valid, ev);
         if (ev && out_valid) begin
            chk("a_out", a_out, exp_q[0].a);
            chk("b_out", b_out, exp_q[0].b);
            chk("ch_out", ch_out, exp_q[0].ch);
            chk("sat_out", sat_out, exp_q[0].sat);
            chk("err_out", err_out, exp_q[0].err);
         end
         if (exp_q.size() == 0) begin
            if (in_valid) begin
               model(g_stan_dev_in, g_avg_in, gamma_in, beta_in, e.a, e.b, e.sat, e.err);
               e.ch  = ch_in;
               e.rdy = cyc + 1 + (e.err ? 0 : N + 1);
               exp_q.push_back(e);
            end
         end else if (ev && out_ready) begin
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic scramble();
      ch_in         = CW'($urandom);
      g_stan_dev_in = DW'($urandom);
      g_avg_in      = DW'($urandom);
      gamma_in      = DW'($urandom);
      beta_in       = DW'($urandom);
   endtask

   task automatic send(input logic [CW-1:0] ch, input logic [DW-1:0] s, m, g, b, output int acc);
      int n = 0;
      @(posedge clk); #1;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (!in_ready) chk("send timeout", 0, 1);
      in_valid = 1'b1; ch_in = ch; g_stan_dev_in = s; g_avg_in = m; gamma_in = g; beta_in = b;
      @(posedge clk); #1;
      acc = cyc;
      in_valid = 1'b0;
      scramble();
   endtask

   task automatic wait_out(output int t);
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      if (!out_valid) chk("out timeout", 0, 1);
      t = cyc;
   endtask

   task automatic expect_out(input string nm, input logic [DW-1:0] a, b, input logic [CW-1:0] ch,
                             input logic sat, err);
      chk({nm, " a"}, a_out, a);
      chk({nm, " b"}, b_out, b);
      chk({nm, " ch"}, ch_out, ch);
      chk({nm, " sat"}, sat_out, sat);
      chk({nm, " err"}, err_out, err);
   endtask

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: actual=running required=done");
      $display("Result: errors=%0d of %0d checks", errors, checks + 1);
      $finish;
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      int acc, t, c_rel;
      logic [DW-1:0] ma, mb, a0, b0;
      logic [CW-1:0] c0;
      logic ms, me;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      ch_in = '0; g_stan_dev_in = '0; g_avg_in = '0; gamma_in = '0; beta_in = '0;
      #2;
      chk("reset in_ready", in_ready, 1);
      expect_out("reset", 16'h0000, 16'h0000, 6'd0, 1'b0, 1'b0);
      chk("reset out_valid", out_valid, 0);

      model(16'h0200, 16'h0100, 16'h0100, 16'h0080, ma, mb, ms, me);
      chk("model basic", {ma, mb}, 32'h0080_0000);
      model(16'h0080, 16'h0100, 16'hFF00, 16'h0000, ma, mb, ms, me);
      chk("model sign", {ma, mb}, 32'hFE00_0200);
      model(16'h0001, 16'h0100, 16'h7FFF, 16'h8000, ma, mb, ms, me);
      chk("model sat", {ma, mb, 15'd0, ms}, {32'h7FFF_8000, 16'h0001});
      model(16'hFF00, 16'h0100, 16'h0100, 16'h1234, ma, mb, ms, me);
      chk("model bypass", {ma, mb, 15'd0, me}, {32'h0000_1234, 16'h0001});

      repeat (2) @(posedge clk); #1 rst_n = 1'b1;

      send(6'd5, 16'h0200, 16'h0100, 16'h0100, 16'h0080, acc);
      wait_out(t);
      chk("basic latency", t - acc, N + 1);
      expect_out("basic", 16'h0080, 16'h0000, 6'd5, 1'b0, 1'b0);

      send(6'd6, 16'h0080, 16'h0100, 16'hFF00, 16'h0000, acc);
      wait_out(t);
      expect_out("sign", 16'hFE00, 16'h0200, 6'd6, 1'b0, 1'b0);

      send(6'd7, 16'h0001, 16'h0100, 16'h7FFF, 16'h8000, acc);
      wait_out(t);
      expect_out("satur", 16'h7FFF, 16'h8000, 6'd7, 1'b1, 1'b0);

      send(6'd8, 16'h0000, 16'h0100, 16'h0100, 16'h1234, acc);
      wait_out(t);
      chk("bypass0 latency", t - acc, 0);
      expect_out("bypass0", 16'h0000, 16'h1234, 6'd8, 1'b0, 1'b1);

      send(6'd9, 16'hFF00, 16'h0100, 16'h0100, 16'h1234, acc);
      wait_out(t);
      chk("bypassneg latency", t - acc, 0);
      expect_out("bypassneg", 16'h0000, 16'h1234, 6'd9, 1'b0, 1'b1);

      @(posedge clk); #1 out_ready = 1'b0;
      send(6'd10, 16'h0300, 16'h0200, 16'h0180, 16'h0040, acc);
      wait_out(t);
      a0 = a_out; b0 = b_out; c0 = ch_out;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (i == 2) begin
            in_valid = 1'b1; ch_in = 6'd33; g_stan_dev_in = '0; beta_in = 16'h5555;
         end
         if (i == 6) in_valid = 1'b0;
         @(negedge clk);
         chk("stall hold", {a_out, b_out}, {a0, b0});
         chk("stall ch", ch_out, c0);
         chk("stall valid", {out_valid, in_ready}, 2'b10);
      end
      @(posedge clk); #1;
      c_rel = cyc;
      out_ready = 1'b1;
      send(6'd11, 16'h0100, 16'h0100, 16'h0300, 16'h0000, acc);
      chk("accept after consume", acc, c_rel + 2);
      wait_out(t);
      expect_out("post stall", 16'h0300, 16'hFD00, 6'd11, 1'b0, 1'b0);

      send(6'd12, 16'h0200, 16'h0100, 16'h0100, 16'h0080, acc);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset valid", {out_valid, in_ready}, 2'b01);
      expect_out("midreset", 16'h0000, 16'h0000, 6'd0, 1'b0, 1'b0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      send(6'd13, 16'h0200, 16'h0100, 16'h0100, 16'h0080, acc);
      wait_out(t);
      chk("after reset latency", t - acc, N + 1);
      expect_out("after reset", 16'h0080, 16'h0000, 6'd13, 1'b0, 1'b0);

      rand_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         logic [DW-1:0] s;
         case ($urandom_range(0, 7))
            0:       s = '0;
            1:       s = DW'($urandom_range(32768, 65535));
            2:       s = DW'($urandom_range(1, 15));
            default: s = DW'($urandom_range(1, 32767));
         endcase
         send(CW'($urandom), s, DW'($urandom), DW'($urandom), DW'($urandom), acc);
      end
      begin
         int n = 0;
         while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); n++; end
         chk("drain", exp_q.size(), 0);
      end
      rand_ready = 1'b0;
      @(posedge clk); #2 out_ready = 1'b1;
      repeat (3) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
